// File: rtl/reorder_buffer_pkg.sv
// ---------------------------------------------------------------------------
// rob_pkg
// Shared definitions for the reorder buffer and its bus interface.
// The physical register width comes from the same register counts the
// rename table is built from, so the two blocks cannot drift apart.
// Contents:
//   AREG_BITS, PHYS_ADDR_BITS, ROB_DEPTH, SEQ_NUM_BITS  - width constants
//   rob_entry_t                                         - one ROB slot
// ---------------------------------------------------------------------------
package rob_pkg;

    localparam int RT_NUM_AREGS   = 32;
    localparam int RT_NUM_PREGS   = 64;
    localparam int AREG_BITS      = $clog2(RT_NUM_AREGS);
    localparam int PHYS_ADDR_BITS = $clog2(RT_NUM_PREGS);
    localparam int ROB_DEPTH      = 16;
    localparam int SEQ_NUM_BITS   = $clog2(ROB_DEPTH);

    typedef struct packed {
        logic                      valid;
        logic                      done;
        logic [AREG_BITS-1:0]      areg;
        logic [PHYS_ADDR_BITS-1:0] preg;
        logic [PHYS_ADDR_BITS-1:0] ppreg;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// ---------------------------------------------------------------------------
// rob_if
// Allocate / complete / commit bus between the rename and execute stages and
// the reorder buffer.
//   master : rename/execute side - drives alloc_* and complete_*, sees commit_*
//   slave  : reorder buffer      - drives alloc_rdy/alloc_seq_num and commit_*
// ---------------------------------------------------------------------------
interface rob_if
    import rob_pkg::*;
#(
    parameter int p_phys_addr_bits = PHYS_ADDR_BITS,
    parameter int p_seq_num_bits   = SEQ_NUM_BITS
);
    logic                        alloc_val;
    logic                        alloc_rdy;
    logic [AREG_BITS-1:0]        alloc_areg;
    logic [p_phys_addr_bits-1:0] alloc_preg;
    logic [p_phys_addr_bits-1:0] alloc_ppreg;
    logic [p_seq_num_bits-1:0]   alloc_seq_num;

    logic                        complete_val;
    logic [p_seq_num_bits-1:0]   complete_seq_num;

    logic                        commit_val;
    logic [p_seq_num_bits-1:0]   commit_seq_num;
    logic [AREG_BITS-1:0]        commit_areg;
    logic [p_phys_addr_bits-1:0] commit_preg;
    logic [p_phys_addr_bits-1:0] commit_ppreg;

    modport master (
        output alloc_val, alloc_areg, alloc_preg, alloc_ppreg,
        output complete_val, complete_seq_num,
        input  alloc_rdy, alloc_seq_num,
        input  commit_val, commit_seq_num, commit_areg, commit_preg, commit_ppreg
    );

    modport slave (
        input  alloc_val, alloc_areg, alloc_preg, alloc_ppreg,
        input  complete_val, complete_seq_num,
        output alloc_rdy, alloc_seq_num,
        output commit_val, commit_seq_num, commit_areg, commit_preg, commit_ppreg
    );
endinterface

// File: rtl/reorder_buffer_wrap_ptr.sv
// ---------------------------------------------------------------------------
// wrap_ptr
// Circular pointer of p_idx_bits index bits plus one wrap bit. The wrap bit
// lets the owner tell full from empty when the index bits are equal.
//   clk     in   clock
//   rst     in   asynchronous active-low reset, pointer to 0
//   incr_i  in   advance by one this cycle
//   idx_o   out  index bits
//   wrap_o  out  wrap bit
// ---------------------------------------------------------------------------
module wrap_ptr #(
    parameter int p_idx_bits = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  incr_i,
    output logic [p_idx_bits-1:0] idx_o,
    output logic                  wrap_o
);
    logic [p_idx_bits:0] ptr_q;
    logic [p_idx_bits:0] ptr_d;

    assign ptr_d = ptr_q + {{p_idx_bits{1'b0}}, incr_i};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

    assign idx_o  = ptr_q[p_idx_bits-1:0];
    assign wrap_o = ptr_q[p_idx_bits];
endmodule

// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
// In-order reorder buffer behind the rename table. Entries are allocated at
// the tail, marked done on completion and retired from the head in program
// order; commit_ppreg feeds the rename table's free list.
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-low reset, discards every entry
//   rob  slave modport of rob_if (alloc / complete / commit)
// Build option ROB_COMMIT_BYPASS_EN: the head may commit in the same cycle
// its completion arrives, without its done bit being written.
// ---------------------------------------------------------------------------
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int p_depth          = ROB_DEPTH,
    parameter int p_phys_addr_bits = PHYS_ADDR_BITS,
    parameter int p_seq_num_bits   = $clog2(p_depth)
) (
    input  logic clk,
    input  logic rst,
    rob_if.slave rob
);
    logic [p_seq_num_bits-1:0]   head_idx;
    logic [p_seq_num_bits-1:0]   tail_idx;
    logic                        head_wrap;
    logic                        tail_wrap;
    logic                        full;
    logic                        alloc_fire;
    logic                        commit_fire;
    logic [p_phys_addr_bits-1:0] commit_preg;
    logic [p_phys_addr_bits-1:0] commit_ppreg;
    rob_entry_t                  head_entry;
    rob_entry_t                  entries_q [p_depth];
    rob_entry_t                  entries_d [p_depth];

    wrap_ptr #(.p_idx_bits(p_seq_num_bits)) u_head (
        .clk    (clk),
        .rst    (rst),
        .incr_i (commit_fire),
        .idx_o  (head_idx),
        .wrap_o (head_wrap)
    );

    wrap_ptr #(.p_idx_bits(p_seq_num_bits)) u_tail (
        .clk    (clk),
        .rst    (rst),
        .incr_i (alloc_fire),
        .idx_o  (tail_idx),
        .wrap_o (tail_wrap)
    );

    assign full       = (head_idx == tail_idx) && (head_wrap != tail_wrap);
    assign alloc_fire = rob.alloc_val && !full;
    assign head_entry = entries_q[head_idx];

`ifdef ROB_COMMIT_BYPASS_EN
    logic complete_hit_head;
    assign complete_hit_head = rob.complete_val && (rob.complete_seq_num == head_idx);
    assign commit_fire       = head_entry.valid && (head_entry.done || complete_hit_head);
`else
    assign commit_fire       = head_entry.valid && head_entry.done;
`endif

    // Commit clears the head slot after any completion write, so a bypassed
    // head never keeps a stale done bit. Allocation cannot alias the head
    // slot while it commits: that would need the buffer to be both full and
    // non-empty-at-head with a free tail.
    always_comb begin
        entries_d = entries_q;
        if (rob.complete_val && entries_q[rob.complete_seq_num].valid)
            entries_d[rob.complete_seq_num].done = 1'b1;
        if (commit_fire)
            entries_d[head_idx] = '0;
        if (alloc_fire) begin
            entries_d[tail_idx].valid = 1'b1;
            entries_d[tail_idx].done  = 1'b0;
            entries_d[tail_idx].areg  = rob.alloc_areg;
            entries_d[tail_idx].preg  = rob.alloc_preg;
            // No destination means nothing to free; ppreg 0 is ignored downstream.
            entries_d[tail_idx].ppreg = (rob.alloc_areg == '0) ? '0 : rob.alloc_ppreg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < p_depth; i++) entries_q[i] <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

    assign commit_preg  = commit_fire ? head_entry.preg  : '0;
    assign commit_ppreg = commit_fire ? head_entry.ppreg : '0;

    assign rob.alloc_rdy      = !full;
    assign rob.alloc_seq_num  = tail_idx;
    assign rob.commit_val     = commit_fire;
    assign rob.commit_seq_num = commit_fire ? head_idx : '0;
    assign rob.commit_areg    = commit_fire ? head_entry.areg : '0;
    assign rob.commit_preg    = commit_preg;
    assign rob.commit_ppreg   = commit_ppreg;

`ifndef SYNTHESIS
    complete_valid_a: assert property (@(posedge clk) disable iff (!rst)
        rob.complete_val |-> entries_q[rob.complete_seq_num].valid);
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
    localparam int DEPTH = 4;
    localparam int SB    = 2;
    localparam int PB    = 6;
`ifdef ROB_COMMIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rob_if #(.p_phys_addr_bits(PB), .p_seq_num_bits(SB)) rob_bus ();

    reorder_buffer #(.p_depth(DEPTH), .p_phys_addr_bits(PB)) dut (
        .clk (clk),
        .rst (rst),
        .rob (rob_bus)
    );

    typedef struct {
        int seq;
        int areg;
        int preg;
        int ppreg;
    } exp_t;

    exp_t sb[$];
    int n_assert = 0;
    int n_fail = 0;
    int model_tail = 0;
    int model_cnt = 0;
    int n_commit = 0;
    int c_start;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard model of the allocate/commit side, evaluated once per cycle.
    task automatic observe();
        exp_t e;
        if (rob_bus.alloc_val) begin
            chk("alloc_rdy", {31'd0, rob_bus.alloc_rdy}, (model_cnt < DEPTH) ? 32'd1 : 32'd0);
            if (model_cnt < DEPTH) begin
                chk("alloc_seq", {30'd0, rob_bus.alloc_seq_num}, model_tail);
                e.seq   = model_tail;
                e.areg  = int'(rob_bus.alloc_areg);
                e.preg  = int'(rob_bus.alloc_preg);
                e.ppreg = (rob_bus.alloc_areg == 5'd0) ? 0 : int'(rob_bus.alloc_ppreg);
                sb.push_back(e);
                model_tail = (model_tail + 1) % DEPTH;
                model_cnt++;
            end
        end
        if (rob_bus.commit_val === 1'b1) begin
            if (sb.size() == 0) begin
                chk("commit_unexpected", {31'd0, rob_bus.commit_val}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("commit_seq",   {30'd0, rob_bus.commit_seq_num}, e.seq);
                chk("commit_areg",  {27'd0, rob_bus.commit_areg},    e.areg);
                chk("commit_preg",  {26'd0, rob_bus.commit_preg},    e.preg);
                chk("commit_ppreg", {26'd0, rob_bus.commit_ppreg},   e.ppreg);
                model_cnt--;
                n_commit++;
            end
        end else begin
            chk("idle_commit_fields",
                {rob_bus.commit_seq_num, rob_bus.commit_areg, rob_bus.commit_preg, rob_bus.commit_ppreg}, 32'd0);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_exp(input string tag, input logic exp_cv);
        @(negedge clk);
        chk(tag, {31'd0, rob_bus.commit_val}, {31'd0, exp_cv});
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rob_bus.alloc_val        = 1'b0;
        rob_bus.alloc_areg       = '0;
        rob_bus.alloc_preg       = '0;
        rob_bus.alloc_ppreg      = '0;
        rob_bus.complete_val     = 1'b0;
        rob_bus.complete_seq_num = '0;
    endtask

    task automatic alloc(input int a, input int p, input int pp);
        rob_bus.alloc_val   = 1'b1;
        rob_bus.alloc_areg  = 5'(a);
        rob_bus.alloc_preg  = 6'(p);
        rob_bus.alloc_ppreg = 6'(pp);
    endtask

    task automatic complete(input int s);
        rob_bus.complete_val     = 1'b1;
        rob_bus.complete_seq_num = 2'(s);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdy"}, {31'd0, rob_bus.alloc_rdy}, 32'd1);
        chk({tag, "_seq"}, {30'd0, rob_bus.alloc_seq_num}, 32'd0);
        chk({tag, "_cv"},  {31'd0, rob_bus.commit_val}, 32'd0);
        chk({tag, "_fields"},
            {rob_bus.commit_seq_num, rob_bus.commit_areg, rob_bus.commit_preg, rob_bus.commit_ppreg}, 32'd0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        sb.delete();
        model_tail = 0;
        model_cnt  = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int i = 0;
        idle();
        while (sb.size() > 0 && i < max_cyc) begin
            cyc();
            i++;
        end
        chk(tag, sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle();

        // 1: single instruction, complete the cycle after allocation
        do_reset();
        alloc(3, 33, 3);
        cyc_exp("t1_cv_at_alloc", 1'b0);
        idle();
        complete(0);
        cyc_exp("t1_cv_at_complete", BYP);
        idle();
        cyc_exp("t1_cv_after_complete", !BYP);
        cyc_exp("t1_cv_idle", 1'b0);

        // 2: out-of-order completion, in-order retirement
        do_reset();
        alloc(5, 40, 5);  cyc();
        alloc(6, 41, 6);  cyc();
        alloc(0, 42, 7);  cyc();
        idle();
        complete(2); cyc_exp("t2_no_commit_c2", 1'b0);
        complete(1); cyc_exp("t2_no_commit_c1", 1'b0);
        complete(0); cyc_exp("t2_complete0", BYP);
        idle();
        cyc_exp("t2_commit_a", 1'b1);
        cyc_exp("t2_commit_b", 1'b1);
        cyc_exp("t2_commit_c", !BYP);
        cyc_exp("t2_idle", 1'b0);

        // 3: full, ignored fifth allocation, wrap-around
        do_reset();
        for (int k = 0; k < 4; k++) begin
            alloc(k + 1, 10 + k, k + 1);
            cyc();
        end
        alloc(9, 50, 9);
        @(negedge clk);
        chk("t3_full_rdy", {31'd0, rob_bus.alloc_rdy}, 32'd0);
        observe();
        @(posedge clk); #1;
        idle();
        complete(0);
        @(negedge clk);
        chk("t3_rdy_complete_cycle", {31'd0, rob_bus.alloc_rdy}, 32'd0);
        chk("t3_cv_complete_cycle", {31'd0, rob_bus.commit_val}, {31'd0, BYP});
        observe();
        @(posedge clk); #1;
        idle();
        if (!BYP) begin
            @(negedge clk);
            chk("t3_rdy_commit_cycle", {31'd0, rob_bus.alloc_rdy}, 32'd0);
            chk("t3_cv_commit_cycle", {31'd0, rob_bus.commit_val}, 32'd1);
            observe();
            @(posedge clk); #1;
        end
        alloc(11, 51, 11);
        @(negedge clk);
        chk("t3_rdy_after_commit", {31'd0, rob_bus.alloc_rdy}, 32'd1);
        chk("t3_wrap_seq", {30'd0, rob_bus.alloc_seq_num}, 32'd0);
        observe();
        @(posedge clk); #1;
        idle();
        complete(1); cyc();
        complete(2); cyc();
        complete(3); cyc();
        complete(0); cyc();
        drain("t3_drain", 10);

        // 4: steady state, one alloc / complete / commit per cycle
        do_reset();
        c_start = n_commit;
        for (int k = 0; k < 14; k++) begin
            idle();
            if (k < 12) alloc((k % 7) + 1, 20 + k, (k % 5) + 1);
            if (k >= 1 && k <= 12) complete((k - 1) % DEPTH);
            cyc();
        end
        drain("t4_drain", 8);
        chk("t4_commit_count", n_commit - c_start, 32'd12);
        chk("t4_tail_wrap", {31'd0, dut.tail_wrap}, 32'd1);
        chk("t4_head_wrap", {31'd0, dut.head_wrap}, 32'd1);

        // 5: asynchronous reset discards pending entries
        do_reset();
        alloc(4, 30, 4); cyc();
        alloc(0, 31, 9); cyc();
        idle();
        complete(0);
        cyc_exp("t5_cv_complete_cycle", BYP);
        idle();
        #2;
        chk("t5_cv_before_rst", {31'd0, rob_bus.commit_val}, {31'd0, !BYP});
        rst = 1'b0;
        #1;
        chk("t5_cv_in_rst", {31'd0, rob_bus.commit_val}, 32'd0);
        sb.delete();
        model_tail = 0;
        model_cnt  = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("t5_after_release");

`ifdef ROB_COMMIT_BYPASS_EN
        // 6: commit in the same cycle as the head completion
        do_reset();
        alloc(7, 20, 7);
        cyc();
        idle();
        complete(0);
        cyc_exp("t6_bypass_same_cycle", 1'b1);
        idle();
        cyc_exp("t6_idle", 1'b0);
`endif

        chk("sb_empty_at_end", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order reorder buffer directly downstream of the rename table. Each renamed instruction gets an entry holding its architectural destination, new physical register and previous physical register. Entries are marked done on completion notifications. Entries retire strictly in program order as commit notifications, whose `ppreg` field drives the rename table's free-list release.

## Interface
- `p_depth`, 16: number of entries; power of two, ≥2.
- `p_phys_addr_bits`, 6: physical register address width; matches the rename table.
- `p_seq_num_bits`, `$clog2(p_depth)`: width of the sequence tag (the entry index).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `alloc_val`  in  1  rename stage presents an instruction to allocate.
- `alloc_rdy`  out  1  entry available; transfer happens when `alloc_val & alloc_rdy`.
- `alloc_areg`  in  5  architectural destination; 0 means no destination.
- `alloc_preg`  in  `p_phys_addr_bits`  newly allocated physical register.
- `alloc_ppreg`  in  `p_phys_addr_bits`  previous mapping of `alloc_areg`, freed at commit.
- `alloc_seq_num`  out  `p_seq_num_bits`  tag assigned to the current allocation; equals the tail index.
- `complete_val`  in  1  an instruction finished execution.
- `complete_seq_num`  in  `p_seq_num_bits`  tag of the finished instruction.
- `commit_val`  out  1  one instruction retires this cycle.
- `commit_seq_num`  out  `p_seq_num_bits`  tag of the retiring instruction.
- `commit_areg`  out  5  its architectural destination.
- `commit_preg`  out  `p_phys_addr_bits`  its physical destination.
- `commit_ppreg`  out  `p_phys_addr_bits`  physical register to free.

## Operation
- **Storage:** circular array of `{valid, done, areg, preg, ppreg}`.
  - Head and tail pointers are `p_seq_num_bits+1` bits wide; the MSB is a wrap bit.
  - Empty when the pointers are fully equal. Full when the index bits are equal and the wrap bits differ.
- **Allocate:**
  - `alloc_rdy = !full`. It does not depend on a same-cycle commit; no pass-through when full.
  - On transfer, write the entry at tail with valid=1 and done=0, then advance tail by 1 with wrap.
- **Complete:**
  - On `complete_val`, set done at `complete_seq_num`.
  - Completion of an invalid entry is illegal. It must not change state; a simulation-only assertion fires.
- **Commit:**
  - `commit_val = valid[head] & done[head]`, combinational from registered state.
  - On commit, clear valid[head] and advance head. At most one commit per cycle.
  - `commit_*` fields come from the head entry. When `commit_val`=0 they are 0.
- **areg = 0 entries:** still allocate and commit normally with `commit_ppreg`=0. The consumer ignores ppreg 0.
- **Simultaneous events:** alloc, complete and commit in the same cycle are all legal and independent.
  - A complete to head in the same cycle as the commit of head cannot occur, because head is already done.
  - A completion in the same cycle as the allocation of that same tag is illegal.

## Timing
- Reset values: `alloc_rdy`=1, `alloc_seq_num`=0, `commit_val`=0, all `commit_*`=0.
- Reset also clears head, tail and all valid/done bits. Asserting `rst` mid-operation discards every entry immediately, asynchronously, with no commits emitted.
- Allocate → entry valid next cycle.
- Complete → done next cycle → `commit_val` that cycle if the entry is at head.
- Minimum latency: allocation to commit is 2 cycles (complete issued the cycle after allocation).
- Commit throughput: 1 per cycle.
- Full → not full: the cycle after a commit.

## Configuration
- `ROB_COMMIT_BYPASS_EN` defined:
  - `commit_val` also asserts when `complete_val` is high, `complete_seq_num` equals the head index, and head is valid.
  - The head commits in the same cycle as its completion, and its done bit is never written.
  - This saves one cycle of complete-to-commit latency.
- Undefined: commit only from the registered done bit, as described under Operation.

## Structure
- Shared package `rob_pkg` holds `rob_entry_t` (packed `{valid, done, areg, preg, ppreg}`).
- Seq-num width and physical address width are derived in `rob_pkg` from the same constants the rename table uses.
- One sub-module, `wrap_ptr`: a `p_seq_num_bits+1`-bit pointer with an `incr` input, asynchronous active-low reset to 0 and index/wrap outputs. It is instantiated for head and tail.
- Entry array, full/empty logic and the commit mux are inline.

## Test plan
Benches use `p_depth`=4.
1. Alloc `{areg=3, preg=33, ppreg=3}`, then complete seq 0 the next cycle. Required: `alloc_seq_num`=0, `commit_val`=1 one cycle after the complete, with `areg=3`, `preg=33`, `ppreg=3`.
2. Alloc seq 0, 1, 2; complete 2, then 1, then 0. Required: no commit until seq 0 is done; then commits of seq 0, 1, 2 on consecutive cycles.
3. Alloc 4 entries with no completes. Required: `alloc_rdy`=0 and a 5th `alloc_val` is ignored. Complete and commit seq 0. Required: `alloc_rdy`=1 the next cycle, and the next allocation gets seq 0, i.e. wrap-around.
4. Steady state: alloc, complete and commit every cycle for 12 cycles. Required: 12 in-order commits, seq numbers 0,1,2,3,0,…, and the pointer wrap bit toggles.
5. Alloc 2 entries, complete seq 0, assert `rst` mid-cycle. Required: `commit_val`=0 immediately; after release `alloc_rdy`=1 and `alloc_seq_num`=0.
6. With `ROB_COMMIT_BYPASS_EN`, alloc seq 0 then complete seq 0. Required: `commit_val`=1 in the same cycle as `complete_val`.
